// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-divider configuration arbiter.
package clkdiv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_ACK
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_config_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request after last_grant, wrapping.
module rr_arbiter
    import clkdiv_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IW      = idx_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last_grant,
    output logic [IW-1:0]      o_winner,
    output logic               o_valid
);

    int unsigned w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        // Scan farthest-first so the candidate nearest last_grant+1 overwrites the rest.
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            w_idx = 32'(i_last_grant) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (i_req[IW'(w_idx)]) begin
                o_winner = IW'(w_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_config_arbiter.sv
// Round-robin front end that loads one requester's divisor into a shared clock divider
// and acknowledges once the divided clock has produced SETTLE_EDGES rising edges.
module clkdiv_config_arbiter
    import clkdiv_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ       = 4,
    parameter  int unsigned DIVISOR_WIDTH = 16,
    parameter  int unsigned SETTLE_EDGES  = 2,
    localparam int unsigned OW            = idx_width(NUM_REQ),
    localparam int unsigned CW            = $clog2(SETTLE_EDGES + 1)
)(
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             busy,
    output logic [OW-1:0]                    owner,
    output logic [DIVISOR_WIDTH-1:0]         div_divisor,
    output logic                             div_load,
    input  logic                             div_clk_out,
    output logic [DIVISOR_WIDTH-1:0]         active_divisor,
    output logic                             active_valid
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [OW-1:0]            r_last_grant;
    logic [OW-1:0]            r_owner;
    logic [OW-1:0]            w_winner;
    logic [OW-1:0]            w_ack_idx;
    logic                     w_any;
    logic                     r_prev;
    logic                     w_rise;
    logic                     w_grant;
    logic                     w_start_load;
    logic                     w_enter_ack;
    logic                     w_cnt_inc;
    logic                     w_commit;
    logic [DIVISOR_WIDTH-1:0] w_win_div;
    logic [DIVISOR_WIDTH-1:0] r_div_divisor;
    logic [DIVISOR_WIDTH-1:0] r_active_divisor;
    logic                     r_active_valid;
    logic                     r_div_load;
    logic [NUM_REQ-1:0]       r_ack;
    logic [CW-1:0]            r_cnt;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_valid      (w_any)
    );

    always_comb begin
        w_win_div = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_winner == OW'(i)) begin
                w_win_div = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
            end
        end
    end

    assign w_rise    = div_clk_out & ~r_prev;
    // The fast path acks straight from IDLE, before owner has been registered.
    assign w_ack_idx = (r_state == ST_IDLE) ? w_winner : r_owner;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_start_load = 1'b0;
        w_enter_ack  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant = 1'b1;
                    if (r_active_valid && (w_win_div == r_active_divisor)) begin
                        w_state_nxt = ST_ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_state_nxt  = ST_LOAD;
                        w_start_load = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_rise) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == CW'(SETTLE_EDGES - 1)) begin
                        w_state_nxt = ST_ACK;
                        w_enter_ack = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant     <= OW'(NUM_REQ - 1);
            r_owner          <= '0;
            r_div_divisor    <= '0;
            r_div_load       <= 1'b0;
            r_ack            <= '0;
            r_active_divisor <= '0;
            r_active_valid   <= 1'b0;
            r_prev           <= 1'b0;
            r_cnt            <= '0;
        end else begin
            r_prev     <= div_clk_out;
            r_div_load <= w_start_load;
            r_ack      <= w_enter_ack ? (NUM_REQ'(1) << w_ack_idx) : '0;
            if (w_grant) begin
                r_owner       <= w_winner;
                r_div_divisor <= w_win_div;
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_active_divisor <= r_div_divisor;
                r_active_valid   <= 1'b1;
                r_last_grant     <= r_owner;
            end
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign ack            = r_ack;
    assign owner          = r_owner;
    assign div_divisor    = r_div_divisor;
    assign div_load       = r_div_load;
    assign active_divisor = r_active_divisor;
    assign active_valid   = r_active_valid;

endmodule

// File: doc/clkdiv_config_arbiter.md
# clkdiv_config_arbiter

Shares one `configurable_clock_divider` between several requesters that each want to set their own divisor. Round-robin arbitration picks one requester, drives its divisor into the divider with a one-cycle load pulse, waits for the divided clock to settle, then acknowledges the requester. Sits directly in front of the divider, in the same `clk_in` domain. It observes the divider's registered `clk_out` as feedback.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DIVISOR_WIDTH, 16, divisor width; must match the divider
- SETTLE_EDGES, 2, rising edges of divider output to wait after load before ack (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk_in  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request, level, held until ack
- req_divisor  in  NUM_REQ×DIVISOR_WIDTH (packed)  divisor requested by each requester
- ack  out  NUM_REQ  one-cycle, one-hot completion pulse
- busy  out  1  high whenever FSM is not IDLE
- owner  out  $clog2(NUM_REQ)  index of last/current granted requester
- div_divisor  out  DIVISOR_WIDTH  to divider `divisor`
- div_load  out  1  to divider `load`
- div_clk_out  in  1  from divider `clk_out` (registered output, same domain)
- active_divisor  out  DIVISOR_WIDTH  divisor currently settled in divider
- active_valid  out  1  active_divisor is meaningful

## Operation
- FSM states: IDLE, LOAD, SETTLE, ACK.
- IDLE: the round-robin winner is computed combinationally. The search starts at last_grant+1 and wraps.
  - If any req is high, capture the winner into owner and its divisor into div_divisor.
  - Fast path: if active_valid and the winner's divisor equals active_divisor, go to ACK. No load is issued.
  - Otherwise go to LOAD.
- LOAD: div_load=1 for exactly one cycle, then go to SETTLE. Clear the edge counter.
- SETTLE: detect divider rising edges as div_clk_out & ~prev, where prev is registered each cycle.
  - Each edge increments the counter.
  - On the edge that makes count reach SETTLE_EDGES, go to ACK.
- ACK: ack[owner]=1 for one cycle. active_divisor←div_divisor and active_valid←1 at the exit edge. last_grant←owner. Then go to IDLE.
- div_divisor holds stable from grant until the next grant.
- Requests arriving while busy wait; there is no pre-emption.
- Dropping req mid-operation does not abort the operation; ack still pulses.
- A requester clears req on the edge ending its ack cycle. If req is still high in IDLE, it is treated as a new request.
- Round-robin pointer after reset: last_grant=NUM_REQ-1, so requester 0 has first priority.
- Divisor 0 is legal (divide-by-2).
- Edge counter width is $clog2(SETTLE_EDGES+1).
- Reset mid-operation: all state clears immediately. Any in-flight operation is lost and no ack is issued. active_valid=0, so the next request always takes the full load path.

## Timing
- Reset values: ack=0, busy=0, owner=0, div_divisor=0, div_load=0, active_divisor=0, active_valid=0. FSM=IDLE, last_grant=NUM_REQ-1, prev=0.
- Req sampled in cycle [R,R+1) → grant edge G=R+1.
- Full path: div_load high in [G,G+1). The divider loads at G+1. The first divider rise is at edge G+D+2.
  - ack high in [A,A+1), where A = G + D + 3 + 2(D+1)(SETTLE_EDGES−1).
  - IDLE again at A+1.
- Fast path: ack high in [G,G+1). No div_load.
- All outputs are registered except those derived from state (busy).

## Structure
- Package clkdiv_ctrl_pkg holds:
  - the state enum typedef (IDLE/LOAD/SETTLE/ACK);
  - a localparam helper for owner width.
- One sub-module is natural: rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs: req vector and last_grant.
  - Outputs: winner index and any-valid.
  - Purely combinational.
- The FSM, divisor and active registers, and edge detector live in the top.

## Test plan
1. Reset: hold rst_n=0 with random req → all outputs 0 and busy=0. After release with no req, all outputs stay 0.
2. Single request: req[0]=1, D=3, SETTLE_EDGES=2, from an idle reset state → div_load pulses in [G,G+1) with div_divisor=3. ack[0] is high only in [G+14,G+15). active_divisor=3 and active_valid=1 afterwards.
3. Fast path: after test 2, req[0]=1 with D=3 → ack[0] in [G,G+1). div_load never pulses and busy is high for one cycle.
4. Contention: after test 2 (last_grant=0), req[0] (D=1) and req[2] (D=5) are raised together → requester 2 is served first (ack at G+5+3+12=G+20), then requester 0 with D=1. Final active_divisor=1.
5. Reset mid-SETTLE: pulse rst_n low during SETTLE → no ack, outputs return to reset values. Re-issuing the previously settled divisor takes the full load path.
6. Boundary D=0, SETTLE_EDGES=2 → div_load at G, ack at [G+5,G+6), and active_divisor=0 with active_valid=1.
